elm_deserializer: RTL and testbench
===================================

// Module: elm_deserializer
// PURPOSE
// - Receive end of the ELM image serial link; mirror of the image serializer.
// - Collects 16-bit image words tagged with a word index and rebuilds the 256-bit frame.
// - Presents the frame to the ELM compute core over a valid/ready handshake.
// - Checks word ordering and flags sequence errors and overruns.
// PARAMETERS
// - WORD_W   16  width of one serial word
// - N_WORDS  16  words per frame; frame width = WORD_W*N_WORDS = 256
// - CNT_W    5   width of serial_count
// PORTS
// - clock         in   1    system clock, all logic on rising edge
// - set           in   1    synchronous active-high reset
// - serial_img    in   16   serial data word
// - serial_count  in   5    index of serial_img within its frame, 0..15
// - ser_tx        in   1    serial_img/serial_count valid this cycle
// - img_out       out  256  assembled frame; word k sits at [16k+15:16k]
// - img_valid     out  1    img_out holds a complete frame
// - img_ready     in   1    consumer accepts img_out
// - busy          out  1    a frame is partially assembled
// - frame_err     out  1    one-cycle pulse on a sequence error
// - overrun       out  1    one-cycle pulse when a completed frame is dropped
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset: img_out=0, img_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, expected index=0.
// - Reset mid-frame discards partial data. Reset while img_valid=1 drops the held frame.
// - Two buffers: the assembly register asm_buf and the output register img_out.
// - A word is accepted only on cycles with ser_tx=1.
// - ser_tx=0 is a gap. Gaps of any length are legal and leave state unchanged.
// - FSM IDLE: an accepted word with count=0 goes to asm_buf[15:0]; expected index becomes 1; next state ASSEMBLE.
// - FSM IDLE: an accepted word with count!=0 pulses frame_err and stays IDLE.
// - FSM ASSEMBLE: a word with count=expected is written to asm_buf; expected index increments.
// - FSM ASSEMBLE: a word with count!=expected pulses frame_err and discards the partial frame.
//   If that word has count=0, it starts a new frame (expected index=1, stay ASSEMBLE). Otherwise go to IDLE.
// - Any count >= N_WORDS (16..31) is a sequence error.
// - busy=1 exactly while in ASSEMBLE.
// - Completion: word count=15 accepted in order; state returns to IDLE.
//   The frame (asm_buf with the final word merged in) is transferred to img_out.
//   img_valid rises on the next edge, so latency is 1 cycle from the last word.
// - Handshake: the transfer completes on an edge where img_valid=1 and img_ready=1.
//   img_valid clears on that edge unless a new completion loads in the same cycle.
// - img_out is stable while img_valid=1 and img_ready=0.
// - Completion with img_valid=0, or with img_valid=1 and img_ready=1 in the same cycle: the frame loads into img_out and img_valid is 1 afterwards.
// - Completion with img_valid=1 and img_ready=0: the new frame is dropped, overrun pulses, and img_out/img_valid are unchanged.
// - Assembly continues while a frame is held at the output; backpressure never stalls the input side.
// - frame_err and overrun are registered and high for exactly one cycle per event.
// TESTING
// - Reset, then send words 0..15 with ser_tx=1 on consecutive cycles, data 16'hA000+k, img_ready=1.
//   Expect img_valid=1 one cycle after word 15, img_out[16k+15:16k]=16'hA000+k, then img_valid=0.
// - Same frame with 3-cycle ser_tx=0 gaps after words 4 and 11.
//   Expect the identical img_out, busy=1 throughout, and no frame_err.
// - Send words 0..6, then a word with count=9, then a full frame 0..15.
//   Expect one frame_err pulse and only the second frame delivered.
// - Send words 0..7, then a word with count=0, then 1..15.
//   Expect a frame_err pulse and a frame built from the restarted sequence.
// - Deliver frame A with img_ready=0, then send frame B in full.
//   Expect an overrun pulse on B's completion, img_out still A; after img_ready=1 for one edge, img_valid=0.
// - Pulse set high on the cycle word 8 arrives, then send words 0..15.
//   Expect all outputs 0 the cycle after set, no frame_err, and a correct frame.

Source files
------------

// File: rtl/elm_deserializer.sv
// Receive side of the ELM image serial link: gathers indexed 16-bit words into a
// 256-bit frame, checks word order and hands complete frames out over valid/ready.
module elm_deserializer #(
    parameter int WORD_W  = 16,
    parameter int N_WORDS = 16,
    parameter int CNT_W   = 5
) (
    input  logic                        clock,
    input  logic                        set,
    input  logic [WORD_W-1:0]           serial_img,
    input  logic [CNT_W-1:0]            serial_count,
    input  logic                        ser_tx,
    output logic [WORD_W*N_WORDS-1:0]   img_out,
    output logic                        img_valid,
    input  logic                        img_ready,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        overrun
);

    localparam int FRAME_W = WORD_W * N_WORDS;
    localparam int IDX_W   = $clog2(N_WORDS);

    typedef enum logic {
        IDLE,
        ASSEMBLE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_exp;
    logic [FRAME_W-1:0]   r_asm;
    logic [FRAME_W-1:0]   r_img;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_ovr;

    logic [FRAME_W-1:0]   w_asm_merged;
    logic                 w_in_order;
    logic                 w_last;
    logic                 w_load;

    always_comb begin
        // NOTE: give every always_comb output a full default first so the indexed write below cannot infer a latch.
        w_asm_merged = r_asm;
        w_asm_merged[serial_count[IDX_W-1:0]*WORD_W +: WORD_W] = serial_img;
    end

    // In IDLE the expected index is always 0, so one compare covers both states.
    assign w_in_order = (serial_count == r_exp);
    assign w_last     = (r_exp == CNT_W'(N_WORDS - 1));
    assign w_load     = !r_valid || img_ready;

    always_ff @(posedge clock) begin
        // NOTE: the assembly buffer is deliberately not reset; state and expected index decide which words are live.
        if (ser_tx && (w_in_order || serial_count == '0)) begin
            r_asm <= w_asm_merged;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (set) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_img   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            r_ovr <= 1'b0;
            if (r_valid && img_ready) begin
                r_valid <= 1'b0;
            end
            if (ser_tx) begin
                if (w_in_order) begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_exp   <= '0;
                        if (w_load) begin
                            r_img   <= w_asm_merged;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end else begin
                        r_state <= ASSEMBLE;
                        r_exp   <= r_exp + 1'b1;
                    end
                end else begin
                    r_err <= 1'b1;
                    // An out-of-order index 0 can only occur mid-frame; it restarts assembly.
                    if (serial_count == '0) begin
                        r_state <= ASSEMBLE;
                        r_exp   <= CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                        r_exp   <= '0;
                    end
                end
            end
        end
    end

    assign img_out   = r_img;
    assign img_valid = r_valid;
    assign busy      = (r_state == ASSEMBLE);
    assign frame_err = r_err;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_elm_deserializer.sv
// Bench for elm_deserializer: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the frame assembly rules.
module tb_elm_deserializer;

    localparam int W = 16;
    localparam int N = 16;

    logic           clock = 1'b0;
    logic           set;
    logic [W-1:0]   serial_img;
    logic [4:0]     serial_count;
    logic           ser_tx;
    logic [W*N-1:0] img_out;
    logic           img_valid;
    logic           img_ready;
    logic           busy;
    logic           frame_err;
    logic           overrun;

    int errors = 0;
    int checks = 0;

    // Reference model: the partial frame is just the list of words received so far.
    logic [W-1:0]   part[$];
    logic [W*N-1:0] m_img;
    logic           m_valid;
    logic           m_err;
    logic           m_ovr;

    elm_deserializer dut (
        .clock        (clock),
        .set          (set),
        .serial_img   (serial_img),
        .serial_count (serial_count),
        .ser_tx       (ser_tx),
        .img_out      (img_out),
        .img_valid    (img_valid),
        .img_ready    (img_ready),
        .busy         (busy),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic tx, input logic [4:0] cnt,
                         input logic [W-1:0] d, input logic rdy);
        logic old_valid;
        old_valid = m_valid;
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (rst) begin
            part.delete();
            m_img   = '0;
            m_valid = 1'b0;
            return;
        end
        if (m_valid && rdy) m_valid = 1'b0;
        if (tx) begin
            if (int'(cnt) == part.size()) begin
                part.push_back(d);
                if (part.size() == N) begin
                    if (!old_valid || rdy) begin
                        for (int k = 0; k < N; k++) m_img[W*k +: W] = part[k];
                        m_valid = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    part.delete();
                end
            end else begin
                m_err = 1'b1;
                part.delete();
                if (cnt == 5'd0) part.push_back(d);
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic cyc(input logic rst, input logic tx, input logic [4:0] cnt,
                       input logic [W-1:0] d, input logic rdy);
        set          = rst;
        ser_tx       = tx;
        serial_count = cnt;
        serial_img   = d;
        img_ready    = rdy;
        @(posedge clock);
        model(rst, tx, cnt, d, rdy);
        @(negedge clock);
        chk("img_valid", (W*N)'(img_valid), (W*N)'(m_valid));
        chk("img_out",   img_out,           m_img);
        chk("busy",      (W*N)'(busy),      (W*N)'(part.size() != 0));
        chk("frame_err", (W*N)'(frame_err), (W*N)'(m_err));
        chk("overrun",   (W*N)'(overrun),   (W*N)'(m_ovr));
    endtask

    task automatic frame(input logic [W-1:0] base, input logic rdy,
                         input int gap_a, input int gap_b, input int gap_len);
        for (int k = 0; k < N; k++) begin
            cyc(1'b0, 1'b1, 5'(k), base + W'(k), rdy);
            if (k == gap_a || k == gap_b) begin
                for (int g = 0; g < gap_len; g++) cyc(1'b0, 1'b0, 5'd0, '0, rdy);
            end
        end
    endtask

    task automatic expect_frame(input string tag, input logic [W-1:0] base);
        for (int k = 0; k < N; k++) chk(tag, (W*N)'(img_out[W*k +: W]), (W*N)'(base + W'(k)));
    endtask

    initial begin
        m_img   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_ovr   = 1'b0;
        @(negedge clock);

        cyc(1'b1, 1'b0, 5'd0, '0, 1'b1);
        cyc(1'b1, 1'b0, 5'd0, '0, 1'b1);
        chk("reset_out", {img_out, img_valid, busy, frame_err, overrun} == '0 ? '0 : '1, '0);

        // Back-to-back frame, then handshake clears valid.
        frame(16'hA000, 1'b1, -1, -1, 0);
        chk("t1_valid", (W*N)'(img_valid), (W*N)'(1));
        expect_frame("t1_word", 16'hA000);
        cyc(1'b0, 1'b0, 5'd0, '0, 1'b1);
        chk("t1_drain", (W*N)'(img_valid), '0);

        // Gaps inside a frame.
        frame(16'hA000, 1'b1, 4, 11, 3);
        expect_frame("t2_word", 16'hA000);
        cyc(1'b0, 1'b0, 5'd0, '0, 1'b1);

        // Skip to index 9 mid-frame, then a clean frame.
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 5'(k), 16'hB000 + W'(k), 1'b1);
        cyc(1'b0, 1'b1, 5'd9, 16'hB009, 1'b1);
        chk("t3_err", (W*N)'(frame_err), (W*N)'(1));
        chk("t3_idle", (W*N)'(busy), '0);
        frame(16'hC000, 1'b1, -1, -1, 0);
        expect_frame("t3_word", 16'hC000);
        cyc(1'b0, 1'b0, 5'd0, '0, 1'b1);

        // Restart with index 0 mid-frame.
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 5'(k), 16'hD000 + W'(k), 1'b1);
        cyc(1'b0, 1'b1, 5'd0, 16'hE000, 1'b1);
        chk("t4_err", (W*N)'(frame_err), (W*N)'(1));
        chk("t4_busy", (W*N)'(busy), (W*N)'(1));
        for (int k = 1; k < N; k++) cyc(1'b0, 1'b1, 5'(k), 16'hE000 + W'(k), 1'b1);
        expect_frame("t4_word", 16'hE000);
        cyc(1'b0, 1'b0, 5'd0, '0, 1'b1);

        // Overrun: frame A held, frame B dropped.
        frame(16'h1000, 1'b0, -1, -1, 0);
        frame(16'h2000, 1'b0, -1, -1, 0);
        chk("t5_ovr", (W*N)'(overrun), (W*N)'(1));
        expect_frame("t5_hold", 16'h1000);
        cyc(1'b0, 1'b0, 5'd0, '0, 1'b1);
        chk("t5_drain", (W*N)'(img_valid), '0);

        // Reset coinciding with word 8.
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 5'(k), 16'h3000 + W'(k), 1'b1);
        cyc(1'b1, 1'b1, 5'd8, 16'h3008, 1'b1);
        chk("t6_zero", {img_out, img_valid, busy, frame_err, overrun} == '0 ? '0 : '1, '0);
        frame(16'h4000, 1'b1, -1, -1, 0);
        expect_frame("t6_word", 16'h4000);
        cyc(1'b0, 1'b0, 5'd0, '0, 1'b1);

        // Random traffic: mostly in-order words, occasional bad index, reset and backpressure.
        for (int i = 0; i < 800; i++) begin
            logic       r_tx;
            logic       r_rdy;
            logic       r_rst;
            logic [4:0] r_cnt;
            r_tx  = ($urandom_range(0, 3) != 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 14) == 0) r_cnt = 5'($urandom_range(0, 31));
            else                            r_cnt = 5'(part.size());
            cyc(r_rst, r_tx, r_cnt, W'($urandom), r_rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
